// File: rtl/weight_inst_issuer.sv
// Weight-load instruction issuer: queues decoder instructions, validates each one,
// and hands valid ones to the weight loader one at a time via an ap_start/ap_done handshake.
`timescale 1ns/1ps
module weight_inst_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int BUF_DEPTH      = 8192,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic         kernel_clk,
    input  logic         kernel_rst,
    input  logic         inst_valid,
    output logic         inst_ready,
    input  logic [127:0] inst_data,
    output logic         ld_start,
    output logic [127:0] ld_inst,
    input  logic         ld_done,
    output logic         done_valid,
    output logic [15:0]  done_count,
    output logic         err_zero_len,
    output logic         err_range,
    output logic         err_size,
    output logic         err_timeout,
    input  logic         err_clear
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        COMPLETE,
        HALT
    } state_t;

    state_t state, state_nxt;

    logic [127:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt, count_nxt;
    logic         push, pop, empty, full_nxt;
    logic [TW-1:0] tmo_cnt;

    logic [15:0] buf_start, rows, dram_bytes;
    logic [16:0] range_sum;
    logic [25:0] rows_bytes;
    logic        chk_zero, chk_range, chk_size, chk_fail;

    assign push      = inst_valid && inst_ready;
    assign pop       = (state == COMPLETE);
    assign empty     = (wr_ptr == rd_ptr);
    assign wr_nxt    = wr_ptr + {{AW{1'b0}}, push};
    assign rd_nxt    = rd_ptr + {{AW{1'b0}}, pop};
    assign count_nxt = wr_nxt - rd_nxt;
    assign full_nxt  = (count_nxt == (AW + 1)'(FIFO_DEPTH));

    // Checks are evaluated on the latched head, which is what the loader will see.
    assign buf_start  = ld_inst[47:32];
    assign rows       = ld_inst[63:48];
    assign dram_bytes = ld_inst[95:80];
    assign range_sum  = {1'b0, buf_start} + {1'b0, rows};
    assign rows_bytes = {10'b0, rows} << 10;
    assign chk_zero   = (rows == 16'd0);
    assign chk_range  = (range_sum > 17'(BUF_DEPTH));
    assign chk_size   = ({10'b0, dram_bytes} != rows_bytes);
    assign chk_fail   = chk_zero || chk_range || chk_size;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (!empty) state_nxt = CHECK;
            CHECK:    state_nxt = chk_fail ? COMPLETE : ISSUE;
            ISSUE:    state_nxt = WAIT;
            WAIT: begin
                if (ld_done)
                    state_nxt = COMPLETE;
                else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1))
                    state_nxt = HALT;
            end
            COMPLETE: state_nxt = IDLE;
            HALT:     state_nxt = HALT;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
        end
    end

    always_ff @(posedge kernel_clk) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= inst_data;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            inst_ready <= 1'b0;
            ld_start   <= 1'b0;
            ld_inst    <= '0;
            done_valid <= 1'b0;
            done_count <= '0;
            tmo_cnt    <= '0;
        end else begin
            inst_ready <= !full_nxt && (state_nxt != HALT);
            ld_start   <= (state_nxt == ISSUE);
            done_valid <= (state_nxt == COMPLETE);
            if (state_nxt == COMPLETE)
                done_count <= done_count + 16'd1;
            if (state == IDLE && !empty)
                ld_inst <= fifo_mem[rd_ptr[AW-1:0]];
            if (state == ISSUE)
                tmo_cnt <= '0;
            else if (state == WAIT && state_nxt == WAIT)
                tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // A new error outranks a simultaneous clear; the timeout flag only resets.
    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            err_zero_len <= 1'b0;
            err_range    <= 1'b0;
            err_size     <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_zero_len <= (err_zero_len && !err_clear) || (state == CHECK && chk_zero);
            err_range    <= (err_range    && !err_clear) || (state == CHECK && chk_range);
            err_size     <= (err_size     && !err_clear) || (state == CHECK && chk_size);
            err_timeout  <= err_timeout || (state == WAIT && state_nxt == HALT);
        end
    end

endmodule
